// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: valid/ready word handshake into the serial frame transmitter
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter (start, LSB-first data, optional even parity, stop)
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter bit PARITY_EN  = 1
) (
  input  logic            clk,
  input  logic            rstn,
  serial_frame_tx_if.slave tx,
  output logic            tx_out,
  output logic            busy,
  output logic            frame_done
);
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic [DATA_W-1:0] shift_nxt;
  logic              bit_end;
  assign shift_nxt = shift >> 1;
  assign bit_end   = cnt == C_LAST;
  // tx_out is loaded with the value of the upcoming bit so it changes on the bit boundary edge
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      par         <= 1'b0;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      tx.tx_ready <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (tx.tx_valid) begin
          state       <= START;
          shift       <= tx.tx_data;
          par         <= ^tx.tx_data;
          cnt         <= '0;
          tx_out      <= 1'b0;
          busy        <= 1'b1;
          tx.tx_ready <= 1'b0;
        end
        START: if (bit_end) begin
          state  <= DATA;
          idx    <= '0;
          tx_out <= shift[0];
        end
        DATA: if (bit_end) begin
          shift <= shift_nxt;
          if (idx == I_LAST) begin
            state  <= PARITY_EN ? PARITY : STOP;
            tx_out <= PARITY_EN ? par : 1'b1;
          end else begin
            idx    <= idx + 1'b1;
            tx_out <= shift_nxt[0];
          end
        end
        PARITY: if (bit_end) begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
        STOP: if (bit_end) begin
          state       <= IDLE;
          busy        <= 1'b0;
          tx.tx_ready <= 1'b1;
          frame_done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed frame checks on parity and no-parity transmitter instances
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] data = 8'h00;
  logic vld = 1'b0;
  logic sel = 1'b0;
  int pass_n = 0;
  int total_n = 0;
  serial_frame_tx_if #(.DATA_W(8)) a_if ();
  serial_frame_tx_if #(.DATA_W(8)) b_if ();
  assign a_if.tx_data  = data;
  assign b_if.tx_data  = data;
  assign a_if.tx_valid = vld & ~sel;
  assign b_if.tx_valid = vld & sel;
  logic out_a, busy_a, done_a, out_b, busy_b, done_b;
  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .rstn(rstn), .tx(a_if.slave), .tx_out(out_a), .busy(busy_a), .frame_done(done_a));
  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .tx(b_if.slave), .tx_out(out_b), .busy(busy_b), .frame_done(done_b));
  wire o_out  = sel ? out_b : out_a;
  wire o_busy = sel ? busy_b : busy_a;
  wire o_done = sel ? done_b : done_a;
  wire o_rdy  = sel ? b_if.tx_ready : a_if.tx_ready;
  task automatic chk(input string tag, input logic obs, input logic exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask
  task automatic idle_chk(input string tag, input logic done_exp);
    chk({tag, "_out"}, o_out, 1'b1);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_ready"}, o_rdy, 1'b1);
    chk({tag, "_done"}, o_done, done_exp);
  endtask
  // Called at a negedge with data/vld set; checks every cycle of the frame and the frame_done cycle.
  // At frame cycles 10 and 11 tx_data/tx_valid are disturbed to prove they are ignored while busy.
  task automatic frame(input logic [10:0] exp, input int nb, input logic v0,
                       input logic [7:0] md, input logic v10, input logic v11);
    for (int k = 0; k < 200 && !o_rdy; k++) @(negedge clk);
    chk("ready_wait", o_rdy, 1'b1);
    @(negedge clk);
    for (int c = 0; c < nb * 4; c++) begin
      if (c == 0) vld = v0;
      if (c == 10) begin
        data = md;
        vld  = v10;
      end
      if (c == 11) vld = v11;
      chk($sformatf("bit%0d_cyc%0d", c / 4, c), o_out, exp[c/4]);
      chk($sformatf("busy_cyc%0d", c), o_busy, 1'b1);
      chk($sformatf("ready_cyc%0d", c), o_rdy, 1'b0);
      chk($sformatf("done_cyc%0d", c), o_done, 1'b0);
      @(negedge clk);
    end
    idle_chk("frame_done", 1'b1);
  endtask
  initial begin
    data = 8'hAA;
    vld  = 1'b1;
    @(negedge clk);
    idle_chk("rst0", 1'b0);
    @(negedge clk);
    idle_chk("rst1", 1'b0);
    vld  = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    idle_chk("post_rst", 1'b0);
    data = 8'hA5;
    vld  = 1'b1;
    frame({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    idle_chk("a5_after", 1'b0);
    data = 8'h01;
    vld  = 1'b1;
    frame({1'b1, 1'b1, 8'h01, 1'b0}, 11, 1'b0, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    sel  = 1'b1;
    vld  = 1'b1;
    frame({1'b0, 1'b1, 8'h01, 1'b0}, 10, 1'b0, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    idle_chk("nopar_after", 1'b0);
    sel  = 1'b0;
    data = 8'h3C;
    vld  = 1'b1;
    frame({1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b1, 8'hC3, 1'b1, 1'b1);
    frame({1'b1, 1'b0, 8'hC3, 1'b0}, 11, 1'b0, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_chk("no_second", 1'b0);
    end
    data = 8'h55;
    vld  = 1'b1;
    for (int k = 0; k < 200 && !o_rdy; k++) @(negedge clk);
    chk("ready_55", o_rdy, 1'b1);
    @(negedge clk);
    vld = 1'b0;
    repeat (17) @(negedge clk);
    chk("d3_out", o_out, 1'b0);
    chk("d3_busy", o_busy, 1'b1);
    #2 rstn = 1'b0;
    #1 idle_chk("async_rst", 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk("rst_release", 1'b0);
    end
    data = 8'h0F;
    vld  = 1'b1;
    frame({1'b1, 1'b0, 8'h0F, 1'b0}, 11, 1'b0, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    idle_chk("end", 1'b0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end
endmodule
